// File: rtl/spi_debug_requester.sv
// SPI master for the debug link: sends 32-bit requests MSB first (CPOL=0) and captures
// each response one frame later; single-request or full latch/register-file sweep.
module spi_debug_requester #(
    parameter int NB_BITS = 32,
    parameter int NB_REG  = 5,
    parameter int CLK_DIV = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [NB_BITS-1:0] i_req_word,
    input  logic               i_miso,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic               o_cs_n,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_data_valid,
    output logic [5:0]         o_index,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NB_BITS);
    localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(NB_BITS - 1);

    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic               phase_q, phase_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [5:0]         frame_q, frame_d;
    logic               mode_q, mode_d;
    logic [NB_BITS-1:0] req_q, req_d;
    logic [NB_BITS-1:0] tx_q, tx_d;
    logic [NB_BITS-1:0] rx_q, rx_d;
    logic [NB_BITS-1:0] data_q, data_d;
    logic [5:0]         index_q, index_d;
    logic               valid_q, valid_d;
    logic [5:0]         last_frame;
    logic               cs_active;

    // Frames 0..3 read the Decode latches, 4..35 the register file; 36 repeats 35 as the dummy.
    function automatic logic [NB_BITS-1:0] sweep_word(input logic [5:0] f);
        logic [NB_BITS-1:0] w;
        logic [NB_REG-1:0]  r;
        w = '0;
        r = '0;
        if (f < 6'd4) begin
            w[22:21] = f[1:0];
        end else begin
            r = (f > 6'd35) ? {NB_REG{1'b1}} : NB_REG'(f - 6'd4);
            w[23] = 1'b1;
            w[16 +: NB_REG] = r;
        end
        return w;
    endfunction

    assign last_frame = mode_q ? 6'd36 : 6'd1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        req_d   = req_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    req_d   = i_req_word;
                    frame_d = 6'd0;
                    tx_d    = i_mode ? sweep_word(6'd0) : i_req_word;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_q == DMAX) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        rx_d    = {rx_q[NB_BITS-2:0], i_miso};
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BMAX) begin
                            state_d = GAP;
                            // rx of frame 0 answers no request, so it is dropped
                            if (frame_q != 6'd0) begin
                                data_d  = rx_q;
                                index_d = frame_q - 6'd1;
                                valid_d = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                            tx_d  = {tx_q[NB_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_q == DMAX) begin
                    div_d = '0;
                    if (frame_q == last_frame) begin
                        state_d = DONE;
                    end else begin
                        frame_d = frame_q + 6'd1;
                        tx_d    = mode_q ? sweep_word(frame_q + 6'd1) : req_q;
                        state_d = LOAD;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            frame_q <= '0;
            mode_q  <= 1'b0;
            req_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            req_q   <= req_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    assign cs_active    = (state_q == LOAD) || (state_q == SHIFT);
    assign o_cs_n       = !cs_active;
    assign o_sclk       = (state_q == SHIFT) && phase_q;
    assign o_mosi       = cs_active && tx_q[NB_BITS-1];
    assign o_data       = data_q;
    assign o_index      = index_q;
    assign o_data_valid = valid_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);

endmodule
